// File: rtl/ts_carpici_pkg.sv
// Shared constants for the ts_carpici multiplier: RV32M operation codes and default sizing.
package ts_carpici_pkg;

   localparam int unsigned SOZCUK_GENISLIGI_BIT      = 32;
   localparam int unsigned VARSAYILAN_HER_CEVRIM_BIT = 2;

   typedef enum logic [1:0] {
      IslemMul    = 2'b00,
      IslemMulh   = 2'b01,
      IslemMulhsu = 2'b10,
      IslemMulhu  = 2'b11
   } islem_e;

endpackage

// File: rtl/ts_carpici_adim.sv
// Combinational R-step shift-add slice: each step conditionally adds |a| into the high half,
// then shifts {acc, b} right by one. The carry lives in the W+1-bit sum and is shifted back in.
module ts_carpici_adim
   import ts_carpici_pkg::*;
#(
   parameter int unsigned Genislik = SOZCUK_GENISLIGI_BIT,
   parameter int unsigned AdimBit  = VARSAYILAN_HER_CEVRIM_BIT
) (
   input  logic [Genislik-1:0] acc_i,
   input  logic [Genislik-1:0] b_i,
   input  logic [Genislik-1:0] a_i,
   output logic [Genislik-1:0] acc_o,
   output logic [Genislik-1:0] b_o
);

   logic [Genislik-1:0] acc_t;
   logic [Genislik-1:0] b_t;
   logic [Genislik:0]   toplam;

   always_comb begin
      acc_t  = acc_i;
      b_t    = b_i;
      toplam = '0;
      for (int i = 0; i < int'(AdimBit); i++) begin
         toplam = b_t[0] ? ({1'b0, acc_t} + {1'b0, a_i}) : {1'b0, acc_t};
         b_t    = {toplam[0], b_t[Genislik-1:1]};
         acc_t  = toplam[Genislik:1];
      end
      acc_o = acc_t;
      b_o   = b_t;
   end

endmodule

// File: rtl/ts_carpici.sv
// Multi-cycle RV32M multiplier (MUL/MULH/MULHSU/MULHU) with a basla/hazir handshake.
// Optional CARPMA_ERKEN_BITIS_EN: finish early once the remaining multiplier bits are all zero.
module ts_carpici
   import ts_carpici_pkg::*;
#(
   parameter int unsigned SOZCUK_GENISLIGI      = SOZCUK_GENISLIGI_BIT,
   parameter int unsigned CARPMA_HER_CEVRIM_BIT = VARSAYILAN_HER_CEVRIM_BIT
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic [SOZCUK_GENISLIGI-1:0] carpilan_i,
   input  logic [SOZCUK_GENISLIGI-1:0] carpan_i,
   input  logic [1:0]                  islem_i,
   input  logic                        basla_i,
   output logic [SOZCUK_GENISLIGI-1:0] sonuc_o,
   output logic                        mesgul_o,
   output logic                        hazir_o
);

   localparam int unsigned W          = SOZCUK_GENISLIGI;
   localparam int unsigned AdimSayisi = W / CARPMA_HER_CEVRIM_BIT;
   localparam int unsigned SayacW     = $clog2(AdimSayisi + 1);

   logic [SayacW-1:0] sayac_q, sayac_d;
   logic [W-1:0]      acc_q, acc_d, b_q, b_d, a_q, a_d, sonuc_q, sonuc_d;
   islem_e            islem_q, islem_d;
   logic              isaret_q, isaret_d, hazir_q, hazir_d;

   islem_e       islem_in;
   logic         a_neg, b_neg, sifir;
   logic [W-1:0] a_mag, b_mag;

   // Magnitude prep; -2^(W-1) negates to itself, which is the correct unsigned magnitude.
   always_comb begin
      islem_in = islem_e'(islem_i);
      a_neg    = carpilan_i[W-1] && (islem_in == IslemMulh || islem_in == IslemMulhsu);
      b_neg    = carpan_i[W-1] && (islem_in == IslemMulh);
      a_mag    = a_neg ? (~carpilan_i + 1'b1) : carpilan_i;
      b_mag    = b_neg ? (~carpan_i + 1'b1) : carpan_i;
      sifir    = (carpilan_i == '0) || (carpan_i == '0);
   end

   logic [W-1:0] acc_n, b_n;

   ts_carpici_adim #(
      .Genislik (W),
      .AdimBit  (CARPMA_HER_CEVRIM_BIT)
   ) u_adim (
      .acc_i (acc_q),
      .b_i   (b_q),
      .a_i   (a_q),
      .acc_o (acc_n),
      .b_o   (b_n)
   );

   logic           son;
   logic [2*W-1:0] carpim, carpim_s;

`ifdef CARPMA_ERKEN_BITIS_EN
   int unsigned  kalan;
   logic [W-1:0] maske;

   // After this cycle's steps the low 'kalan' bits of b_n are the still-unprocessed multiplier bits.
   always_comb begin
      kalan  = 32'(sayac_q - 1'b1) * CARPMA_HER_CEVRIM_BIT;
      maske  = (W'(1) << kalan) - W'(1);
      son    = (sayac_q == SayacW'(1)) || ((b_n & maske) == '0);
      carpim = {acc_n, b_n} >> kalan;
   end
`else
   always_comb begin
      son    = (sayac_q == SayacW'(1));
      carpim = {acc_n, b_n};
   end
`endif

   always_comb begin
      sayac_d  = sayac_q;
      acc_d    = acc_q;
      b_d      = b_q;
      a_d      = a_q;
      islem_d  = islem_q;
      isaret_d = isaret_q;
      sonuc_d  = sonuc_q;
      hazir_d  = 1'b0;
      carpim_s = isaret_q ? (~carpim + 1'b1) : carpim;

      if (sayac_q == '0) begin
         if (basla_i) begin
            // A zero operand runs a single cycle on an all-zero datapath.
            sayac_d  = sifir ? SayacW'(1) : SayacW'(AdimSayisi);
            acc_d    = '0;
            b_d      = sifir ? '0 : b_mag;
            a_d      = a_mag;
            islem_d  = islem_in;
            isaret_d = ~sifir & (a_neg ^ b_neg);
         end
      end else if (son) begin
         sayac_d  = '0;
         hazir_d  = 1'b1;
         sonuc_d  = (islem_q == IslemMul) ? carpim_s[W-1:0] : carpim_s[2*W-1:W];
         acc_d    = '0;
         b_d      = '0;
         isaret_d = 1'b0;
      end else begin
         sayac_d = sayac_q - 1'b1;
         acc_d   = acc_n;
         b_d     = b_n;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sayac_q  <= '0;
         acc_q    <= '0;
         b_q      <= '0;
         a_q      <= '0;
         islem_q  <= IslemMul;
         isaret_q <= 1'b0;
         sonuc_q  <= '0;
         hazir_q  <= 1'b0;
      end else begin
         sayac_q  <= sayac_d;
         acc_q    <= acc_d;
         b_q      <= b_d;
         a_q      <= a_d;
         islem_q  <= islem_d;
         isaret_q <= isaret_d;
         sonuc_q  <= sonuc_d;
         hazir_q  <= hazir_d;
      end
   end

   assign sonuc_o  = sonuc_q;
   assign hazir_o  = hazir_q;
   assign mesgul_o = (sayac_q != '0);

endmodule

// File: tb/tb_ts_carpici.sv
// Directed bench for ts_carpici; latency expectations follow CARPMA_ERKEN_BITIS_EN when defined.
module tb_ts_carpici;
   import ts_carpici_pkg::*;

`ifdef CARPMA_ERKEN_BITIS_EN
   localparam bit ERKEN = 1'b1;
`else
   localparam bit ERKEN = 1'b0;
`endif

   logic        clk, rst, basla, mesgul, hazir;
   logic [31:0] carpilan, carpan, sonuc;
   logic [1:0]  islem;

   int n_checks = 0;
   int n_errors = 0;

   ts_carpici dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .carpilan_i (carpilan),
      .carpan_i   (carpan),
      .islem_i    (islem),
      .basla_i    (basla),
      .sonuc_o    (sonuc),
      .mesgul_o   (mesgul),
      .hazir_o    (hazir)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic baslat(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
      carpilan = a;
      carpan   = b;
      islem    = op;
      basla    = 1'b1;
   endtask

   // Waits for the accept edge, scrambles inputs (must be ignored), then times the hazir pulse.
   task automatic bekle(input string tag, input logic [31:0] exp, input int lat_d, input int lat_e,
                        input bit tekrar);
      int lat;
      @(posedge clk); #1;
      check({tag, "/mesgul"}, 32'(mesgul), 32'd1);
      basla    = tekrar;
      carpilan = ~carpilan;
      carpan   = carpan ^ 32'h5A5A_5A5A;
      islem    = ~islem;
      lat      = 0;
      do begin
         @(posedge clk); #1;
         basla = 1'b0;
         lat++;
      end while (!hazir && lat < 40);
      check({tag, "/gecikme"}, 32'(lat), 32'(ERKEN ? lat_e : lat_d));
      check({tag, "/sonuc"}, sonuc, exp);
      check({tag, "/bitis"}, 32'({mesgul, hazir}), 32'b01);
   endtask

   task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] op, input logic [31:0] exp, input int lat_d,
                         input int lat_e);
      @(negedge clk);
      baslat(a, b, op);
      bekle(tag, exp, lat_d, lat_e, 1'b0);
   endtask

   initial begin
      int hz;
      rst      = 1'b1;
      basla    = 1'b0;
      carpilan = '0;
      carpan   = '0;
      islem    = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset/sonuc", sonuc, 32'h0);
      check("reset/hazir", 32'(hazir), 32'h0);
      check("reset/mesgul", 32'(mesgul), 32'h0);
      rst = 1'b0;

      run_op("mulhu_ff",  32'hFFFF_FFFF, 32'hFFFF_FFFF, IslemMulhu,  32'hFFFF_FFFE, 16, 16);
      run_op("mul_ff",    32'hFFFF_FFFF, 32'hFFFF_FFFF, IslemMul,    32'h0000_0001, 16, 16);
      run_op("mulh_min",  32'h8000_0000, 32'h8000_0000, IslemMulh,   32'h4000_0000, 16, 16);
      run_op("mul_min",   32'h8000_0000, 32'h8000_0000, IslemMul,    32'h0000_0000, 16, 16);
      run_op("mulhsu",    32'h8000_0000, 32'hFFFF_FFFF, IslemMulhsu, 32'h8000_0000, 16, 16);
      run_op("mulhsu_m1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, IslemMulhsu, 32'hFFFF_FFFF, 16, 16);
      run_op("mulh_m7x3", 32'hFFFF_FFF9, 32'h0000_0003, IslemMulh,   32'hFFFF_FFFF, 16, 1);
      run_op("mul_m7x3",  32'hFFFF_FFF9, 32'h0000_0003, IslemMul,    32'hFFFF_FFEB, 16, 1);
      run_op("mul_erken", 32'h1234_5678, 32'h0000_0003, IslemMul,    32'h369D_0368, 16, 1);
      run_op("mulh_b0",   32'h0000_0005, 32'h0000_0000, IslemMulh,   32'h0000_0000, 1, 1);

      // Zero shortcut, then back-to-back issue on the hazir cycle.
      run_op("mul_zero",  32'h0000_0000, 32'h0000_1234, IslemMul,    32'h0000_0000, 1, 1);
      baslat(32'd5, 32'd6, IslemMul);
      bekle("b2b_5x6", 32'd30, 16, 2, 1'b0);

      // A start request while busy must be ignored.
      @(negedge clk);
      baslat(32'd7, 32'd9, IslemMul);
      bekle("mesgul_7x9", 32'd63, 16, 2, 1'b1);

      // Reset mid-operation aborts without a hazir pulse.
      @(negedge clk);
      baslat(32'd3, 32'd4, IslemMul);
      @(posedge clk); #1;
      basla = 1'b0;
      repeat (4) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("abort/sonuc", sonuc, 32'h0);
      check("abort/hazir", 32'(hazir), 32'h0);
      check("abort/mesgul", 32'(mesgul), 32'h0);
      hz = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (hazir) hz++;
      end
      check("abort/darbe", 32'(hz), 32'h0);
      run_op("abort_3x4", 32'd3, 32'd4, IslemMul, 32'd12, 16, 2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
